// File: rtl/spi_flash_emu_if.sv
// Pad-side and preload signals of the SPI NOR flash emulator.
// The emulator takes the slave modport; a bench or SoC top drives the master side.
interface spi_flash_emu_if #(
  parameter int NUM_CS  = 2,
  parameter int BANK_AW = 12
);
  localparam int LBW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                spi_sclk_i;
  logic [NUM_CS-1:0]   spi_cs_n_i;
  logic                spi_mosi_i;
  logic                spi_miso_o;
  logic                spi_miso_oe_o;
  logic                load_we_i;
  logic [LBW-1:0]      load_bank_i;
  logic [BANK_AW-1:0]  load_addr_i;
  logic [7:0]          load_data_i;
  logic                cs_conflict_o;
  logic [15:0]         xfer_cnt_o;

  modport slave (
    input  spi_sclk_i, spi_cs_n_i, spi_mosi_i,
    input  load_we_i, load_bank_i, load_addr_i, load_data_i,
    output spi_miso_o, spi_miso_oe_o, cs_conflict_o, xfer_cnt_o
  );

  modport master (
    output spi_sclk_i, spi_cs_n_i, spi_mosi_i,
    output load_we_i, load_bank_i, load_addr_i, load_data_i,
    input  spi_miso_o, spi_miso_oe_o, cs_conflict_o, xfer_cnt_o
  );
endinterface

// File: rtl/spi_flash_emu.sv
// Oversampled SPI NOR flash emulator (mode 0) with one byte bank per chip select.
// Serves READ, FAST_READ, RDID and RDSR; banks are filled through the preload port.
module spi_flash_emu #(
  parameter int          NUM_CS       = 2,
  parameter int          BANK_AW      = 12,
  parameter int          ADDR_BYTES   = 3,
  parameter int          DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'h20BA18
) (
  input logic             clk_i,
  input logic             rst_i,
  spi_flash_emu_if.slave  bus
);
  localparam int              LBW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int              DEPTH      = 1 << BANK_AW;
  localparam logic [7:0]      ADDR_LAST  = 8'(ADDR_BYTES * 8 - 1);
  localparam logic [7:0]      DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam bit              USE_DUMMY  = (DUMMY_CYCLES > 0);
  localparam logic [LBW:0]    NUM_CS_W   = (LBW + 1)'(NUM_CS);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE} state_t;
  typedef enum logic [1:0] {MODE_MEM, MODE_ID, MODE_STS} mode_t;

  state_t              r_state, w_stateNext;
  mode_t               r_mode;
  logic                r_sclkS1, r_sclkS2, r_sclkD;
  logic                r_mosiS1, r_mosiS2;
  logic [NUM_CS-1:0]   r_csS1, r_csS2;
  logic                w_rise, w_fall;
  logic                w_anyLow, w_multiLow, w_allHigh;
  logic [LBW-1:0]      w_csIdx;
  logic [LBW-1:0]      r_bank;
  logic [7:0]          r_bitCnt;
  logic [6:0]          r_shift;
  logic [7:0]          w_opcode;
  logic [BANK_AW-1:0]  r_addr;
  logic                r_dummyEn;
  logic [1:0]          r_idIdx;
  logic [7:0]          r_dout;
  logic [7:0]          w_byte;
  logic [7:0]          r_rdData;
  logic                r_miso;
  logic                r_conflict;
  logic [15:0]         r_xferCnt;
  logic                w_loadOk;
  logic [7:0]          r_mem [NUM_CS][DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sclkS1 <= 1'b0;
      r_sclkS2 <= 1'b0;
      r_sclkD  <= 1'b0;
      r_mosiS1 <= 1'b0;
      r_mosiS2 <= 1'b0;
      r_csS1   <= '1;
      r_csS2   <= '1;
    end else begin
      r_sclkS1 <= bus.spi_sclk_i;
      r_sclkS2 <= r_sclkS1;
      r_sclkD  <= r_sclkS2;
      r_mosiS1 <= bus.spi_mosi_i;
      r_mosiS2 <= r_mosiS1;
      r_csS1   <= bus.spi_cs_n_i;
      r_csS2   <= r_csS1;
    end
  end

  assign w_rise   = r_sclkS2 & ~r_sclkD;
  assign w_fall   = ~r_sclkS2 & r_sclkD;
  assign w_opcode = {r_shift, r_mosiS2};

  always_comb begin
    w_anyLow   = 1'b0;
    w_multiLow = 1'b0;
    w_csIdx    = '0;
    for (int k = 0; k < NUM_CS; k++) begin
      if (!r_csS2[k]) begin
        if (w_anyLow) w_multiLow = 1'b1;
        w_anyLow = 1'b1;
        w_csIdx  = LBW'(k);
      end
    end
  end
  assign w_allHigh = ~w_anyLow;

  // Preload write and SPI read share a cycle; the NBA read returns the old byte on a collision.
  assign w_loadOk = ({1'b0, bus.load_bank_i} < NUM_CS_W);
  always_ff @(posedge clk_i) begin
    if (bus.load_we_i && w_loadOk) r_mem[bus.load_bank_i][bus.load_addr_i] <= bus.load_data_i;
    r_rdData <= r_mem[r_bank][r_addr];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_allHigh) begin
      w_stateNext = ST_IDLE;
    end else if (w_multiLow) begin
      w_stateNext = ST_IGNORE;
    end else if (r_state != ST_IDLE && r_state != ST_IGNORE && w_csIdx != r_bank) begin
      w_stateNext = ST_IGNORE;
    end else begin
      case (r_state)
        ST_IDLE:  w_stateNext = ST_CMD;
        ST_CMD: begin
          if (w_rise && r_bitCnt == 8'd7) begin
            case (w_opcode)
              8'h03, 8'h0B: w_stateNext = ST_ADDR;
              8'h9F, 8'h05: w_stateNext = ST_DATA;
              default:      w_stateNext = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (w_rise && r_bitCnt == ADDR_LAST)
            w_stateNext = (r_dummyEn && USE_DUMMY) ? ST_DUMMY : ST_DATA;
        end
        ST_DUMMY: begin
          if (w_rise && r_bitCnt == DUMMY_LAST) w_stateNext = ST_DATA;
        end
        default: w_stateNext = r_state;
      endcase
    end
  end

  always_comb begin
    w_byte = r_rdData;
    case (r_mode)
      MODE_ID: begin
        case (r_idIdx)
          2'd0:    w_byte = JEDEC_ID[23:16];
          2'd1:    w_byte = JEDEC_ID[15:8];
          default: w_byte = JEDEC_ID[7:0];
        endcase
      end
      MODE_STS: w_byte = 8'h00;
      default:  w_byte = r_rdData;
    endcase
  end

  // A transaction counts only if CS rises on a byte boundary of the data phase.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bank     <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_mode     <= MODE_MEM;
      r_dummyEn  <= 1'b0;
      r_idIdx    <= '0;
      r_dout     <= '0;
      r_miso     <= 1'b0;
      r_conflict <= 1'b0;
      r_xferCnt  <= '0;
    end else begin
      if (w_multiLow) r_conflict <= 1'b1;
      if (r_state == ST_DATA && w_allHigh && r_bitCnt == 8'd0) r_xferCnt <= r_xferCnt + 16'd1;
      if (r_state == ST_IDLE) r_bank <= w_csIdx;

      if (w_stateNext != r_state) begin
        r_bitCnt <= '0;
      end else if (w_rise) begin
        if (r_state == ST_DATA) r_bitCnt <= (r_bitCnt == 8'd7) ? 8'd0 : r_bitCnt + 8'd1;
        else                    r_bitCnt <= r_bitCnt + 8'd1;
      end

      if (w_rise && r_state == ST_CMD) begin
        r_shift <= w_opcode[6:0];
        if (r_bitCnt == 8'd7) begin
          r_dummyEn <= (w_opcode == 8'h0B);
          r_idIdx   <= '0;
          case (w_opcode)
            8'h9F:   r_mode <= MODE_ID;
            8'h05:   r_mode <= MODE_STS;
            default: r_mode <= MODE_MEM;
          endcase
        end
      end

      if (w_rise && r_state == ST_ADDR) r_addr <= {r_addr[BANK_AW-2:0], r_mosiS2};

      if (w_rise && r_state == ST_DATA && w_stateNext == ST_DATA && r_bitCnt == 8'd7) begin
        r_addr  <= r_addr + 1'b1;
        r_idIdx <= (r_idIdx == 2'd2) ? 2'd0 : r_idIdx + 2'd1;
      end

      if (w_fall && r_state == ST_DATA) begin
        if (r_bitCnt == 8'd0) begin
          r_miso <= w_byte[7];
          r_dout <= {w_byte[6:0], 1'b0};
        end else begin
          r_miso <= r_dout[7];
          r_dout <= {r_dout[6:0], 1'b0};
        end
      end
    end
  end

  assign bus.spi_miso_o    = r_miso;
  assign bus.spi_miso_oe_o = (r_state == ST_DATA) && !w_multiLow;
  assign bus.cs_conflict_o = r_conflict;
  assign bus.xfer_cnt_o    = r_xferCnt;
endmodule
